// File: rtl/chaos_key_pkg.sv
// Shared types and helpers for the chaotic-LFSR keystream FIFO.
// Parity helper is used only when KEY_FIFO_PARITY_EN is defined.
package chaos_key_pkg;

    localparam int KEY_W  = 8;
    localparam int TRIP_W = 3 * KEY_W;
    localparam int PAR_W  = 3;

    typedef enum logic [0:0] {
        WARM = 1'b0,
        RUN  = 1'b1
    } key_state_e;

    // Even parity, one bit per byte, ordered {R, G, B}
    function automatic logic [PAR_W-1:0] trip_parity(input logic [TRIP_W-1:0] trip);
        trip_parity = {^trip[3*KEY_W-1:2*KEY_W], ^trip[2*KEY_W-1:KEY_W], ^trip[KEY_W-1:0]};
    endfunction

endpackage

// File: rtl/key_fifo_mem.sv
// Triplet storage for rgb_key_fifo: DEPTH x EW register array,
// one synchronous write port and one asynchronous read port.
module key_fifo_mem
    import chaos_key_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int EW    = TRIP_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [EW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [EW-1:0] rdata
);

    logic [EW-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/rgb_key_fifo.sv
// First-word-fall-through keystream FIFO with start-up warm-up discard.
// Optional per-byte parity protection: define KEY_FIFO_PARITY_EN.
module rgb_key_fifo
    import chaos_key_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int WARMUP = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          Key_ready,
    input  logic [7:0]    R_random,
    input  logic [7:0]    G_random,
    input  logic [7:0]    B_random,
    input  logic          key_take,
    output logic          key_valid,
    output logic [7:0]    R_key,
    output logic [7:0]    G_key,
    output logic [7:0]    B_key,
    output logic [AW:0]   level,
    output logic          overflow
`ifdef KEY_FIFO_PARITY_EN
    ,
    output logic          parity_err
`endif
);

`ifdef KEY_FIFO_PARITY_EN
    localparam int EW = TRIP_W + PAR_W;
`else
    localparam int EW = TRIP_W;
`endif
    localparam int              WCW       = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WCW-1:0]  WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [WCW-1:0]  WCNT_ONE  = WCW'(1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [AW:0]     LVL_ONE   = (AW+1)'(1);
    localparam logic [AW:0]     LVL_FULL  = (AW+1)'(DEPTH);
    // With no warm-up there is nothing to discard, so start (and restart) in RUN
    localparam key_state_e      START_ST  = (WARMUP == 0) ? RUN : WARM;

    key_state_e        state_r;
    logic [WCW-1:0]    warm_cnt_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic [AW:0]       level_nxt_s;
    logic              valid_r;
    logic              overflow_r;
    logic [TRIP_W-1:0] hold_r;
    logic [TRIP_W-1:0] head_s;
    logic [TRIP_W-1:0] trip_s;
    logic [EW-1:0]     wr_entry_s;
    logic [EW-1:0]     rd_entry_s;
    logic              full_s;
    logic              wr_s;
    logic              pop_s;
    logic              push_s;

    key_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .EW    (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    // Write/pop qualification and next occupancy; flush overrides both
    always_comb begin
        trip_s = {R_random, G_random, B_random};
`ifdef KEY_FIFO_PARITY_EN
        wr_entry_s = {trip_s, trip_parity(trip_s)};
`else
        wr_entry_s = trip_s;
`endif
        full_s = (level_r == LVL_FULL);
        wr_s   = (state_r == RUN) && Key_ready && !flush;
        pop_s  = valid_r && key_take && !flush;
        push_s = wr_s && (!full_s || pop_s);
        head_s = valid_r ? rd_entry_s[EW-1 -: TRIP_W] : hold_r;
        if (flush) begin
            level_nxt_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + LVL_ONE;
                2'b01:   level_nxt_s = level_r - LVL_ONE;
                default: level_nxt_s = level_r;
            endcase
        end
    end

    // Warm-up FSM: swallow the first WARMUP strobes after reset or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= START_ST;
            warm_cnt_r <= '0;
        end else if (flush) begin
            state_r    <= START_ST;
            warm_cnt_r <= '0;
        end else begin
            case (state_r)
                WARM: begin
                    if (Key_ready) begin
                        if (warm_cnt_r == WARM_LAST) begin
                            state_r    <= RUN;
                            warm_cnt_r <= '0;
                        end else begin
                            warm_cnt_r <= warm_cnt_r + WCNT_ONE;
                        end
                    end
                end
                RUN:     state_r <= RUN;
                default: state_r <= START_ST;
            endcase
        end
    end

    // Pointers, occupancy, sticky overflow and the head value held while empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            hold_r     <= '0;
        end else begin
            if (push_s) wr_ptr_r <= flush ? '0 : wr_ptr_r + PTR_ONE;
            else if (flush) wr_ptr_r <= '0;
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            else if (flush) rd_ptr_r <= '0;
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != '0);
            if (flush) overflow_r <= 1'b0;
            else if (wr_s && full_s && !pop_s) overflow_r <= 1'b1;
            if (valid_r) hold_r <= head_s;
        end
    end

`ifdef KEY_FIFO_PARITY_EN
    logic parity_err_r;

    // One-cycle pulse when a popped entry fails its parity recheck
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= pop_s &&
                (trip_parity(rd_entry_s[EW-1 -: TRIP_W]) != rd_entry_s[PAR_W-1:0]);
        end
    end

    assign parity_err = parity_err_r;
`endif

    assign key_valid = valid_r;
    assign R_key     = head_s[3*KEY_W-1:2*KEY_W];
    assign G_key     = head_s[2*KEY_W-1:KEY_W];
    assign B_key     = head_s[KEY_W-1:0];
    assign level     = level_r;
    assign overflow  = overflow_r;

endmodule
